// File: rtl/irq_ctrl.sv
// Prioritised, maskable interrupt controller for the 68000 IPL interface.
// Synchronises raw sources, latches edges into pending bits and retires them on autovector acknowledge.
module irq_ctrl #(
   parameter int unsigned NUM_SRC     = 3,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] src,
   input  logic               cs,
   input  logic [1:0]         wr,
   input  logic [1:0]         address,
   input  logic [15:0]        din,
   output logic [15:0]        dout,
   input  logic               iack,
   input  logic [2:0]         iack_level,
   output logic [2:0]         ipl_n
);

   localparam int unsigned NW      = NUM_SRC;
   localparam logic [2:0]  MAX_LVL = 3'(NUM_SRC);

   typedef enum logic {S_IDLE, S_ACK} state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0][NW-1:0] sync_q;
   logic [NW-1:0] sync_s, prev, pending, enable, polarity;
   logic [NW-1:0] eff, edge_set, w1c_clr, ack_clr, ack_mask, pending_next;
   logic          spurious, iack_d, iack_rise, ack_take, set_spur, wr_en;
   logic [2:0]    lvl, ipl_n_next;
   logic [7:0]    rd_byte;

   assign sync_s    = sync_q[SYNC_STAGES-1];
   assign iack_rise = iack & ~iack_d;
   assign wr_en     = cs & wr[0];
   assign eff       = pending & enable;

   // An edge needs sync != prev, so a polarity change alone never fires.
   assign edge_set  = (polarity & sync_s & ~prev) | (~polarity & ~sync_s & prev);
   assign w1c_clr   = (wr_en && address == 2'd0) ? din[NW-1:0] : '0;

   // Highest-index effective source wins.
   always_comb begin
      lvl = 3'd0;
      for (int i = 0; i < int'(NW); i++) begin
         if (eff[i]) lvl = 3'(i + 1);
      end
   end

   always_comb begin
      ack_mask = '0;
      if (iack_level != 3'd0 && iack_level <= MAX_LVL)
         ack_mask = NW'(1) << (iack_level - 3'd1);
   end

   always_comb begin
      state_next = state;
      ack_take   = 1'b0;
      case (state)
         S_IDLE: begin
            if (iack_rise) begin
               state_next = S_ACK;
               ack_take   = 1'b1;
            end
         end
         S_ACK: begin
            if (!iack) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      ack_clr    = ack_take ? (ack_mask & pending) : '0;
      set_spur   = ack_take & ~(|(ack_mask & pending));
      ipl_n_next = (state_next == S_ACK) ? 3'b111 : ~lvl;
   end

   // A new edge beats both W1C and acknowledge on the same bit.
   assign pending_next = (pending & ~w1c_clr & ~ack_clr) | edge_set;

   always_comb begin
      rd_byte = 8'd0;
      case (address)
         2'd0: rd_byte = 8'(pending);
         2'd1: rd_byte = 8'(enable);
         2'd2: rd_byte = 8'(polarity);
         2'd3: rd_byte = {spurious, 3'b000, state == S_ACK, ~ipl_n};
         default: rd_byte = 8'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= '0;
         prev     <= '0;
         pending  <= '0;
         enable   <= '0;
         polarity <= '1;
         spurious <= 1'b0;
         iack_d   <= 1'b0;
         ipl_n    <= 3'b111;
         dout     <= 16'd0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], src};
         prev    <= sync_s;
         pending <= pending_next;
         iack_d  <= iack;
         ipl_n   <= ipl_n_next;
         dout    <= {8'd0, rd_byte};
         if (wr_en && address == 2'd1) enable   <= din[NW-1:0];
         if (wr_en && address == 2'd2) polarity <= din[NW-1:0];
         if (set_spur)                          spurious <= 1'b1;
         else if (wr_en && address == 2'd3)     spurious <= 1'b0;
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register table, edge capture, priority and acknowledge sequences.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  src;
   logic        cs;
   logic [1:0]  wr;
   logic [1:0]  address;
   logic [15:0] din;
   logic [15:0] dout;
   logic        iack;
   logic [2:0]  iack_level;
   logic [2:0]  ipl_n;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [15:0] exp;
   } sb_t;
   sb_t sb[$];

   typedef struct {
      logic [1:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl[9];

   irq_ctrl #(.NUM_SRC(3), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .src(src), .cs(cs), .wr(wr), .address(address),
      .din(din), .dout(dout), .iack(iack), .iack_level(iack_level), .ipl_n(ipl_n)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
      end
   endtask

   // Expected read value reflects register state at the moment the address is driven.
   task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string nm);
      sb_t e;
      address = a;
      sb.push_back('{nm, exp});
      step();
      e = sb.pop_front();
      chk(e.name, dout, e.exp);
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
      address = a;
      din     = d;
      cs      = 1'b1;
      wr      = 2'b01;
      step();
      cs      = 1'b0;
      wr      = 2'b00;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      tbl[0] = '{2'd1, 16'h00FF, 16'h0007};
      tbl[1] = '{2'd1, 16'h005A, 16'h0002};
      tbl[2] = '{2'd1, 16'hFF05, 16'h0005};
      tbl[3] = '{2'd1, 16'h0000, 16'h0000};
      tbl[4] = '{2'd2, 16'h00F0, 16'h0000};
      tbl[5] = '{2'd2, 16'h0003, 16'h0003};
      tbl[6] = '{2'd2, 16'h00FF, 16'h0007};
      tbl[7] = '{2'd0, 16'h00FF, 16'h0000};
      tbl[8] = '{2'd3, 16'h0000, 16'h0000};

      reset = 1'b1; src = '0; cs = 1'b0; wr = 2'b00; address = 2'd0;
      din = '0; iack = 1'b0; iack_level = 3'd0;
      steps(3);
      chk("reset_dout", dout, 16'h0000);
      chk("reset_ipl", 16'(ipl_n), 16'h0007);
      reset = 1'b0;
      step();
      rd(2'd0, 16'h0000, "reset_pending");
      rd(2'd1, 16'h0000, "reset_enable");
      rd(2'd2, 16'h0007, "reset_polarity");
      rd(2'd3, 16'h0000, "reset_status");

      for (int i = 0; i < 9; i++) begin
         wr_reg(tbl[i].addr, tbl[i].wdata);
         rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl_%0d", i));
      end

      // Edge latency and no re-trigger while held high
      wr_reg(2'd1, 16'h0007);
      src = 3'b001;
      steps(3);
      chk("lat_k2_ipl", 16'(ipl_n), 16'h0007);
      step();
      chk("lat_k3_ipl", 16'(ipl_n), 16'h0006);
      rd(2'd0, 16'h0001, "lat_pending");
      wr_reg(2'd0, 16'h0001);
      steps(3);
      rd(2'd0, 16'h0000, "held_no_retrig");
      chk("held_ipl", 16'(ipl_n), 16'h0007);
      src = 3'b000;
      steps(4);
      rd(2'd0, 16'h0000, "fall_ignored");

      // Priority and acknowledge
      src = 3'b101;
      steps(4);
      chk("prio_ipl", 16'(ipl_n), 16'h0004);
      iack_level = 3'd3;
      iack = 1'b1;
      step();
      chk("ack_ipl", 16'(ipl_n), 16'h0007);
      rd(2'd0, 16'h0001, "ack_pending");
      rd(2'd3, 16'h0008, "ack_status");
      chk("ack_hold_ipl", 16'(ipl_n), 16'h0007);
      iack = 1'b0;
      step();
      chk("ack_release_ipl", 16'(ipl_n), 16'h0006);
      src = 3'b000;
      wr_reg(2'd0, 16'h0007);
      step();
      chk("clear_all_ipl", 16'(ipl_n), 16'h0007);

      // Masked source, late enable, disable keeps pending
      wr_reg(2'd1, 16'h0002);
      src = 3'b001;
      steps(3);
      src = 3'b000;
      steps(3);
      rd(2'd0, 16'h0001, "masked_pending");
      chk("masked_ipl", 16'(ipl_n), 16'h0007);
      wr_reg(2'd1, 16'h0003);
      chk("enable_same_edge_ipl", 16'(ipl_n), 16'h0007);
      step();
      chk("enable_next_edge_ipl", 16'(ipl_n), 16'h0006);
      wr_reg(2'd1, 16'h0002);
      step();
      chk("disable_ipl", 16'(ipl_n), 16'h0007);
      rd(2'd0, 16'h0001, "disable_keeps_pending");
      wr_reg(2'd0, 16'h0001);

      // Falling-edge polarity
      wr_reg(2'd2, 16'h0005);
      src = 3'b010;
      steps(4);
      rd(2'd0, 16'h0000, "pol_rise_ignored");
      src = 3'b000;
      steps(4);
      rd(2'd0, 16'h0002, "pol_fall_set");
      chk("pol_ipl", 16'(ipl_n), 16'h0005);
      wr_reg(2'd0, 16'h0002);
      rd(2'd0, 16'h0000, "pol_w1c");
      chk("pol_w1c_ipl", 16'(ipl_n), 16'h0007);

      // Spurious acknowledge
      iack_level = 3'd5;
      iack = 1'b1;
      step();
      iack = 1'b0;
      step();
      rd(2'd3, 16'h0080, "spur_status");
      rd(2'd0, 16'h0000, "spur_pending");
      wr_reg(2'd3, 16'h0000);
      rd(2'd3, 16'h0000, "spur_cleared");

      // W1C colliding with an edge: set wins
      src = 3'b001;
      steps(2);
      address = 2'd0; din = 16'h0001; cs = 1'b1; wr = 2'b01;
      step();
      cs = 1'b0; wr = 2'b00;
      rd(2'd0, 16'h0001, "w1c_vs_edge");

      // Long iack clears exactly one bit
      src = 3'b101;
      steps(4);
      rd(2'd0, 16'h0005, "two_pending");
      wr_reg(2'd1, 16'h0007);
      step();
      chk("two_ipl", 16'(ipl_n), 16'h0004);
      iack_level = 3'd3;
      iack = 1'b1;
      step();
      iack_level = 3'd1;
      for (int i = 0; i < 9; i++) begin
         step();
         chk($sformatf("long_ack_ipl_%0d", i), 16'(ipl_n), 16'h0007);
      end
      iack = 1'b0;
      step();
      chk("long_ack_release_ipl", 16'(ipl_n), 16'h0006);
      rd(2'd0, 16'h0001, "long_ack_pending");

      // Reset while in ACK
      src = 3'b000;
      steps(4);
      iack = 1'b1;
      step();
      reset = 1'b1;
      iack = 1'b0;
      steps(2);
      chk("rst_ack_ipl", 16'(ipl_n), 16'h0007);
      reset = 1'b0;
      rd(2'd3, 16'h0000, "rst_ack_status");
      rd(2'd1, 16'h0000, "rst_ack_enable");
      rd(2'd2, 16'h0007, "rst_ack_polarity");
      rd(2'd0, 16'h0000, "rst_ack_pending");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Prioritised, maskable interrupt controller for the 68000 (fx68k) core; replaces the ad-hoc IRQ flag logic in the system top level.
- Synchronises up to 7 raw interrupt sources and captures edges into pending bits.
- Drives the active-low IPL lines and retires the serviced source on the CPU's autovector acknowledge.
- Exposes pending/enable/polarity/status registers on the CPU bus, decoded like the crtc and tilemap blocks.

Parameters:
- NUM_SRC, 3, number of sources (1..7); source i maps to IPL level i+1.
- SYNC_STAGES, 2, synchroniser depth on src (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- src  in  NUM_SRC  raw interrupt inputs, asynchronous allowed
- cs  in  1  register window select (address decode from top level)
- wr  in  2  byte write enables, {UDS,LDS} already qualified with ~rw; only wr[0] has effect
- address  in  2  register index (cpu_addr[2:1])
- din  in  16  CPU write data
- dout  out  16  register read data
- iack  in  1  interrupt acknowledge cycle active (FC==3'b111 & ~AS_n)
- iack_level  in  3  level being acknowledged (cpu_addr[3:1])
- ipl_n  out  3  active-low encoded interrupt level to the CPU IPL2..0

Behaviour:
- Clock and reset:
  - Single clock clk; reset is synchronous, active-high.
  - Reset values: pending=0, enable=0, polarity=all 1 (rising edge), spurious=0, ipl_n=3'b111, dout=0.
  - Synchroniser and edge-history flops are cleared to 0.
- Edge capture:
  - src passes through SYNC_STAGES flops; edge history flop prev holds the last synchronised value.
  - Rising edge detected when polarity[i]=1, sync=1, prev=0.
  - Falling edge detected when polarity[i]=0, sync=0, prev=1.
  - A detected edge sets pending[i] regardless of enable[i].
  - Latency with SYNC_STAGES=2: src change sampled at edge k; pending set at edge k+2; ipl_n updated at edge k+3.
  - Pulses shorter than one clk period may be lost.
- Level generation (registered):
  - eff = pending & enable.
  - ipl_n <= ~(index+1) of the highest set bit of eff; ipl_n <= 3'b111 if eff is 0.
  - Highest source index wins.
- Acknowledge state machine:
  - IDLE: ipl_n tracks eff; on iack rising edge (iack=1, iack_d=0) go to ACK.
    - If pending[iack_level-1] is set and iack_level is in 1..NUM_SRC, clear that bit.
    - Otherwise set spurious.
  - ACK: ipl_n forced to 3'b111 while iack stays 1; on iack=0 return to IDLE and re-evaluate ipl_n on the next edge.
  - Only one pending bit is cleared per acknowledge cycle, however long iack is held.
- Register map (index, low byte only; bits >= NUM_SRC read 0 and ignore writes):
  - 0 PENDING: R; write-1-to-clear.
  - 1 ENABLE: R/W.
  - 2 POLARITY: R/W; 1=rising, 0=falling.
  - 3 STATUS: R; bits [2:0] = current level (~ipl_n), bit 3 = ACK state, bit 7 = spurious. Any write with wr[0] clears spurious.
  - Writes take effect at the clock edge where cs & wr[0].
- Read path:
  - dout <= register[address] every cycle, one-cycle latency, no read side effects.
  - Upper byte of dout is 0. dout is independent of cs.
- Priority and boundary rules:
  - Edge and W1C on the same bit in the same cycle: pending stays 1 (set wins).
  - Edge and ack on the same bit in the same cycle: pending stays 1 (set wins).
  - Changing POLARITY does not itself create an edge, because prev is not compared across the change.
  - Disabling a source while it drives ipl_n drops ipl_n on the next edge; pending is kept.
  - Reset during ACK returns to IDLE with all state at reset values.

Test Plan:
- Reset, then enable=0x07, pulse src[0] high for 3 cycles -> pending=0x01 readable; ipl_n=3'b110 at edge k+3; src[0] held high causes no re-trigger.
- Pend src[0] and src[2] together -> ipl_n=3'b100; iack with iack_level=3 -> pending=0x01, ipl_n=3'b111 while iack=1; after iack drops, ipl_n=3'b110 one edge later.
- enable=0x02, pulse src[0] -> pending=0x01, ipl_n stays 3'b111; write enable=0x03 -> ipl_n=3'b110 next edge.
- polarity[1]=0, drive src[1] 1->0 -> pending bit1 set; 0->1 -> no set. Write PENDING=0x02 -> bit cleared.
- iack with iack_level=5 and nothing pending -> STATUS bit7=1, pending unchanged; write STATUS -> bit7=0.
- W1C on bit0 in the same cycle as a synchronised src[0] edge -> pending bit0 remains 1. iack held 10 cycles with two sources pending -> only one bit cleared.
